fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the single-port instruction memory. Holds the PC and drives memory_address/memory_read_strobe into the memory, whose registered read has 1-cycle latency. Presents each fetched word to decode with a valid/ready handshake and accepts branch/jump redirects from execute. Sustains 1 instruction/cycle when decode is always ready.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings,
// default boot address and the canonical NOP word.
package fetch_unit_pkg;

  // Fetch sequencer states. BOOT lasts exactly one cycle after reset,
  // RUN is the normal fetching state, FAULT is absorbing until reset.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // PC of the first fetch after reset unless overridden at instantiation.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // ADD x0,x0,x0 -- used wherever a harmless instruction word is needed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  // Instructions are word aligned; any redirect with low address bits set
  // is illegal and must not reach the memory.
  function automatic logic is_misaligned(input logic        redir_valid,
                                         input logic [31:0] redir_pc);
    return redir_valid && (redir_pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Holds the PC, issues fetches to a single-port
// instruction memory with a 1-cycle registered read, and presents each
// fetched word to decode with a valid/ready handshake. Redirects from
// execute squash the displayed word and retarget the next fetch in the
// same cycle, so a redirect costs no bubble when fetching is enabled.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] memory_address,
  output logic        memory_read_strobe,
  input  logic [31:0] memory_read_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_enable,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;

  logic         misaligned;
  logic         advance;
  logic         accept;
  logic         strobe;
  logic [31:0]  fetch_addr;

  // Fetch request decode: a redirect overrides the sequential PC, and a
  // new word may only be requested when the displayed one will not be
  // needed any more (empty, accepted, or squashed by the redirect).
  always_comb begin
    misaligned = is_misaligned(redirect_valid, redirect_pc);
    advance    = !valid_q || instr_ready;
    accept     = valid_q && !redirect_valid && instr_ready;
    fetch_addr = redirect_valid ? redirect_pc : pc_q;
    strobe     = (state_q == ST_RUN) && fetch_enable && !misaligned &&
                 (redirect_valid || advance);
  end

  assign memory_address     = fetch_addr;
  assign memory_read_strobe = strobe;
  // The memory holds its output until the next strobe, so decode can take
  // the word straight from the memory with no local copy.
  assign instr              = memory_read_data;
  assign instr_pc           = instr_pc_q;
  assign instr_valid        = valid_q && !redirect_valid;
  assign fault              = fault_q;
  assign fetch_count        = count_q;

  // Next-state logic for the sequencer, PC, output-valid and counters.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    count_d    = count_q;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (misaligned) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    endcase

    if (strobe) begin
      // Word arrives next cycle, so it becomes valid exactly then.
      valid_d    = 1'b1;
      instr_pc_d = fetch_addr;
      pc_d       = fetch_addr + 32'd4;
    end else if (state_q == ST_FAULT) begin
      // Redirects are ignored once faulted; nothing is ever valid again.
      valid_d = 1'b0;
    end else if (misaligned) begin
      // Drop the wrong-path word but keep the PC as it was.
      valid_d = 1'b0;
    end else if (redirect_valid) begin
      // Aligned redirect that could not fetch (BOOT or fetch disabled):
      // remember the target so fetching resumes there.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      count_d = count_q + 32'd1;
    end
  end

  // State registers; reset takes effect immediately so an in-flight word
  // is never marked valid.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_pc_q <= 32'h0000_0000;
      fault_q    <= 1'b0;
      count_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus pushes the expected
// accepted PCs into a queue, a negedge monitor pops and compares on every
// handshake, and the stimulus also checks control outputs directly.
module tb_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] memory_address;
  logic        memory_read_strobe;
  logic [31:0] memory_read_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_enable;
  logic        fault;
  logic [31:0] fetch_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .memory_address     (memory_address),
    .memory_read_strobe (memory_read_strobe),
    .memory_read_data   (memory_read_data),
    .instr              (instr),
    .instr_pc           (instr_pc),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .fetch_enable       (fetch_enable),
    .fault              (fault),
    .fetch_count        (fetch_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: each word is a fixed function of its address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Registered-read instruction memory model, 1-cycle latency.
  always @(posedge CLK) begin
    if (memory_read_strobe) memory_read_data <= word_at(memory_address);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %b (t=%0t)", name, act, $time);
    end
  endtask

  // Scoreboard monitor: every handshake must match the next expected PC.
  always @(negedge CLK) begin
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_accept: got pc %h expected no accept (t=%0t)", instr_pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("accept_pc", instr_pc, e);
        chk("accept_instr", instr, word_at(e));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_fetch(input string name, input logic [31:0] addr);
    chk1({name, "_strobe"}, memory_read_strobe, 1'b1);
    chk({name, "_addr"}, memory_address, addr);
  endtask

  initial begin
    RESET          = 1'b1;
    instr_ready    = 1'b1;
    fetch_enable   = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    tick();
    chk1("rst_strobe", memory_read_strobe, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_count", fetch_count, 32'd0);
    chk1("rst_fault", fault, 1'b0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    RESET = 1'b0;
    #1;
    chk1("boot_strobe", memory_read_strobe, 1'b0);

    // Streaming from address 0
    tick(); #1; chk_fetch("f0", 32'h0); exp_q.push_back(32'h0);
    tick(); #1; chk_fetch("f4", 32'h4); exp_q.push_back(32'h4);
    tick(); #1; chk_fetch("f8", 32'h8); exp_q.push_back(32'h8);

    // Stall for 3 cycles with pc 8 displayed
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("stall_strobe", memory_read_strobe, 1'b0);
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_instr", instr, word_at(32'h8));
      chk("stall_count", fetch_count, 32'd2);
      tick();
    end
    instr_ready = 1'b1;
    #1; chk_fetch("f12", 32'hC); exp_q.push_back(32'hC);
    tick(); #1; chk_fetch("f16", 32'h10);

    // Redirect while pc 16 is displayed and decode is ready
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk1("redir_squash", instr_valid, 1'b0);
    chk_fetch("redir", 32'h40); exp_q.push_back(32'h40);
    chk("redir_count", fetch_count, 32'd4);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_next_pc", instr_pc, 32'h40);
    chk_fetch("f44", 32'h44); exp_q.push_back(32'h44);
    chk("redir_nocount", fetch_count, 32'd4);

    // Fetch disabled with one word pending
    tick();
    fetch_enable = 1'b0;
    #1;
    chk1("dis_strobe", memory_read_strobe, 1'b0);
    chk1("dis_pending", instr_valid, 1'b1);
    chk("dis_count", fetch_count, 32'd5);
    tick(); #1;
    chk1("dis_drained", instr_valid, 1'b0);
    chk1("dis_strobe2", memory_read_strobe, 1'b0);
    chk("dis_count2", fetch_count, 32'd6);
    tick(); #1;
    chk1("dis_strobe3", memory_read_strobe, 1'b0);
    tick();
    fetch_enable = 1'b1;
    #1; chk_fetch("resume", 32'h48); exp_q.push_back(32'h48);
    tick(); #1; chk_fetch("f4c", 32'h4C); exp_q.push_back(32'h4C);
    tick(); #1; chk_fetch("f50", 32'h50);

    // Redirect to the top word; the following fetch wraps to 0
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1; chk_fetch("wrap_top", 32'hFFFF_FFFC); exp_q.push_back(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    #1; chk_fetch("wrap_zero", 32'h0); exp_q.push_back(32'h0);
    tick(); #1; chk_fetch("wrap_four", 32'h4);

    // Asynchronous reset mid-stream
    tick(); #1;
    chk("pre_rst_count", fetch_count, 32'd10);
    chk1("pre_rst_valid", instr_valid, 1'b1);
    RESET = 1'b1;
    #1;
    chk1("arst_valid", instr_valid, 1'b0);
    chk1("arst_strobe", memory_read_strobe, 1'b0);
    chk("arst_count", fetch_count, 32'd0);
    chk("arst_instr_pc", instr_pc, 32'd0);
    tick();
    RESET = 1'b0;
    #1;
    chk1("boot2_strobe", memory_read_strobe, 1'b0);
    tick(); #1; chk_fetch("r0", 32'h0); exp_q.push_back(32'h0);
    tick(); #1; chk_fetch("r4", 32'h4);

    // Misaligned redirect -> sticky fault
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    #1;
    chk1("mis_strobe", memory_read_strobe, 1'b0);
    chk1("mis_valid", instr_valid, 1'b0);
    chk1("mis_fault_early", fault, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk1("fault_set", fault, 1'b1);
    chk1("fault_valid", instr_valid, 1'b0);
    chk1("fault_strobe", memory_read_strobe, 1'b0);
    chk("fault_count", fetch_count, 32'd1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    #1;
    chk1("fault_redir_strobe", memory_read_strobe, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk1("fault_hold_strobe", memory_read_strobe, 1'b0);
    chk("fault_pc_held", memory_address, 32'h8);
    chk1("fault_sticky", fault, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk1("fault_idle_strobe", memory_read_strobe, 1'b0);
    end

    chk("scoreboard_left", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
